// File: rtl/beat_pkg.sv
// Shared types for the beat scheduler slice: lane mask width and scheduler FSM states.
package beat_pkg;

    localparam int LANES = 4;

    typedef logic [LANES-1:0] lane_mask_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        HOLD
    } sched_state_t;

endpackage

// File: rtl/beat_scheduler_if.sv
// Spawn command handshake between beat_scheduler (master) and pattern_gen (slave).
interface beat_scheduler_if;
    import beat_pkg::*;

    logic       spawn_valid;
    lane_mask_t spawn_mask;
    logic       spawn_ready;

    modport master (
        output spawn_valid,
        output spawn_mask,
        input  spawn_ready
    );

    modport slave (
        input  spawn_valid,
        input  spawn_mask,
        output spawn_ready
    );

endinterface

// File: rtl/beat_fifo.sv
// DEPTH-entry lane-mask FIFO with synchronous flush, level count and
// same-cycle push+pop (a push into a full FIFO is accepted only alongside a pop).
module beat_fifo
    import beat_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  lane_mask_t               push_data,
    input  logic                     pop,
    output lane_mask_t               head,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty,
    output logic                     push_accepted
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    lane_mask_t        mem_q [DEPTH];
    lane_mask_t        mem_d [DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]     level_q, level_d;
    logic              pop_acc;

    assign full  = (level_q == LW'(DEPTH));
    assign empty = (level_q == '0);
    assign head  = mem_q[rd_ptr_q];
    assign level = level_q;

    // A pop on empty is ignored, so push_accepted never depends on a phantom pop.
    assign pop_acc       = pop && !empty;
    assign push_accepted = push && (!full || pop_acc);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push_accepted) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + PW'(1);
            end
            if (pop_acc) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            case ({push_accepted, pop_acc})
                2'b10:   level_d = level_q + LW'(1);
                2'b01:   level_d = level_q - LW'(1);
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

endmodule

// File: rtl/beat_scheduler.sv
// Queues receiver beats and issues at most one spawn per frame tick with a tick holdoff.
// Optional: BEAT_SCHED_DROP_EMPTY_EN discards zero lane masks at push.
module beat_scheduler
    import beat_pkg::*;
#(
    parameter int DEPTH         = 8,
    parameter int HOLDOFF_TICKS = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     new_beat,
    input  lane_mask_t               lane_mask,
    input  logic                     frame_tick,
    beat_scheduler_if.master         spawn,
    input  logic                     clear_overflow,
    output logic [$clog2(DEPTH):0]   queue_level,
    output logic                     overflow
);

    sched_state_t state_q, state_d;
    logic         spawn_valid_q, spawn_valid_d;
    lane_mask_t   spawn_mask_q, spawn_mask_d;
    logic [3:0]   hold_cnt_q, hold_cnt_d;
    logic         overflow_q, overflow_d;

    logic         push_req;
    logic         pop;
    logic         push_accepted;
    logic         fifo_full;
    logic         fifo_empty;
    lane_mask_t   fifo_head;

`ifdef BEAT_SCHED_DROP_EMPTY_EN
    assign push_req = new_beat && enable && (lane_mask != '0);
`else
    assign push_req = new_beat && enable;
`endif

    assign pop = (state_q == ISSUE) && spawn.spawn_ready && enable;

    beat_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk           (clk),
        .reset         (reset),
        .flush         (!enable),
        .push          (push_req),
        .push_data     (lane_mask),
        .pop           (pop),
        .head          (fifo_head),
        .level         (queue_level),
        .full          (fifo_full),
        .empty         (fifo_empty),
        .push_accepted (push_accepted)
    );

    always_comb begin
        state_d       = state_q;
        spawn_valid_d = spawn_valid_q;
        spawn_mask_d  = spawn_mask_q;
        hold_cnt_d    = hold_cnt_q;
        overflow_d    = overflow_q;

        if (clear_overflow) overflow_d = 1'b0;
        if (push_req && !push_accepted) overflow_d = 1'b1;

        case (state_q)
            IDLE: begin
                if (frame_tick && !fifo_empty) begin
                    state_d       = ISSUE;
                    spawn_valid_d = 1'b1;
                    spawn_mask_d  = fifo_head;
                end
            end
            ISSUE: begin
                if (spawn.spawn_ready) begin
                    spawn_valid_d = 1'b0;
                    if (HOLDOFF_TICKS == 0) begin
                        state_d = IDLE;
                    end else begin
                        state_d    = HOLD;
                        hold_cnt_d = 4'(HOLDOFF_TICKS);
                    end
                end
            end
            HOLD: begin
                // The final decrement returns to IDLE; that same tick cannot issue.
                if (frame_tick) begin
                    hold_cnt_d = hold_cnt_q - 4'd1;
                    if (hold_cnt_q <= 4'd1) begin
                        hold_cnt_d = '0;
                        state_d    = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (!enable) begin
            state_d       = IDLE;
            spawn_valid_d = 1'b0;
            spawn_mask_d  = '0;
            hold_cnt_d    = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            spawn_valid_q <= 1'b0;
            spawn_mask_q  <= '0;
            hold_cnt_q    <= '0;
            overflow_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            spawn_valid_q <= spawn_valid_d;
            spawn_mask_q  <= spawn_mask_d;
            hold_cnt_q    <= hold_cnt_d;
            overflow_q    <= overflow_d;
        end
    end

    assign spawn.spawn_valid = spawn_valid_q;
    assign spawn.spawn_mask  = spawn_mask_q;
    assign overflow          = overflow_q;

endmodule

// File: tb/tb_beat_scheduler.sv
// Directed self-checking bench for beat_scheduler (DEPTH=8, HOLDOFF_TICKS=2).
module tb_beat_scheduler;
    import beat_pkg::*;

    localparam int DEPTH = 8;

    logic       clk;
    logic       reset;
    logic       enable;
    logic       new_beat;
    lane_mask_t lane_mask;
    logic       frame_tick;
    logic       clear_overflow;
    logic [3:0] queue_level;
    logic       overflow;

    int checks;
    int errors;

    beat_scheduler_if spawn_if ();

    beat_scheduler #(
        .DEPTH         (DEPTH),
        .HOLDOFF_TICKS (2)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .new_beat       (new_beat),
        .lane_mask      (lane_mask),
        .frame_tick     (frame_tick),
        .spawn          (spawn_if),
        .clear_overflow (clear_overflow),
        .queue_level    (queue_level),
        .overflow       (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs applied before an edge are captured by it; outputs are sampled 1ns after it.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input lane_mask_t m);
        new_beat  = 1'b1;
        lane_mask = m;
        cycle();
        new_beat  = 1'b0;
        lane_mask = '0;
    endtask

    task automatic frame();
        frame_tick = 1'b1;
        cycle();
        frame_tick = 1'b0;
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        enable         = 1'b1;
        new_beat       = 1'b0;
        lane_mask      = '0;
        frame_tick     = 1'b0;
        clear_overflow = 1'b0;
        spawn_if.spawn_ready = 1'b0;
        cycle();
        cycle();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({spawn_if.spawn_valid, spawn_if.spawn_mask, queue_level, overflow} !== 10'b0) begin
            errors++;
            $display("FAIL reset: valid=%b mask=%b level=%0d ovf=%b, required all zero",
                     spawn_if.spawn_valid, spawn_if.spawn_mask, queue_level, overflow);
        end
    endtask

    task automatic test_basic();
        do_reset();
        push(4'b0101);
        checks++;
        if (queue_level !== 4'd1) begin
            errors++;
            $display("FAIL basic_level: got %0d, required 1", queue_level);
        end
        frame();
        checks++;
        if (spawn_if.spawn_valid !== 1'b1 || spawn_if.spawn_mask !== 4'b0101) begin
            errors++;
            $display("FAIL basic_issue: valid=%b mask=%b, required 1/0101",
                     spawn_if.spawn_valid, spawn_if.spawn_mask);
        end
        spawn_if.spawn_ready = 1'b1;
        cycle();
        spawn_if.spawn_ready = 1'b0;
        checks++;
        if (spawn_if.spawn_valid !== 1'b0 || queue_level !== 4'd0) begin
            errors++;
            $display("FAIL basic_pop: valid=%b level=%0d, required 0/0",
                     spawn_if.spawn_valid, queue_level);
        end
    endtask

    task automatic test_holdoff();
        logic       got;
        lane_mask_t gm;
        logic       exp_got;
        lane_mask_t exp_m;
        do_reset();
        push(4'b0001);
        push(4'b0010);
        push(4'b0011);
        spawn_if.spawn_ready = 1'b1;
        for (int t = 1; t <= 8; t++) begin
            frame();
            got = spawn_if.spawn_valid;
            gm  = spawn_if.spawn_mask;
            cycle();
            if (spawn_if.spawn_valid === 1'b1) got = 1'b1;
            cycle();
            if (spawn_if.spawn_valid === 1'b1) got = 1'b1;
            exp_got = (t == 1 || t == 4 || t == 7);
            exp_m   = (t == 1) ? 4'b0001 : (t == 4) ? 4'b0010 : 4'b0011;
            checks++;
            if (got !== exp_got || (exp_got && gm !== exp_m)) begin
                errors++;
                $display("FAIL holdoff_tick%0d: spawn=%b mask=%b, required spawn=%b mask=%b",
                         t, got, gm, exp_got, exp_m);
            end
        end
        spawn_if.spawn_ready = 1'b0;
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 1; i <= 9; i++) push(4'(i));
        checks++;
        if (queue_level !== 4'd8 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL overflow_set: level=%0d ovf=%b, required 8/1", queue_level, overflow);
        end
        clear_overflow = 1'b1;
        cycle();
        clear_overflow = 1'b0;
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL overflow_clear: ovf=%b, required 0", overflow);
        end
        spawn_if.spawn_ready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            frame();
            checks++;
            if (spawn_if.spawn_valid !== 1'b1 || spawn_if.spawn_mask !== 4'(k)) begin
                errors++;
                $display("FAIL overflow_drain%0d: valid=%b mask=%b, required 1/%b",
                         k, spawn_if.spawn_valid, spawn_if.spawn_mask, 4'(k));
            end
            cycle();
            frame();
            frame();
        end
        frame();
        checks++;
        if (spawn_if.spawn_valid !== 1'b0 || queue_level !== 4'd0) begin
            errors++;
            $display("FAIL overflow_dropped: valid=%b mask=%b level=%0d, required 0/-/0",
                     spawn_if.spawn_valid, spawn_if.spawn_mask, queue_level);
        end
        spawn_if.spawn_ready = 1'b0;
    endtask

    task automatic test_stall_disable();
        do_reset();
        push(4'b1010);
        push(4'b0110);
        frame();
        for (int i = 0; i < 5; i++) begin
            frame_tick = (i % 2 == 0);
            cycle();
            frame_tick = 1'b0;
            checks++;
            if (spawn_if.spawn_valid !== 1'b1 || spawn_if.spawn_mask !== 4'b1010 ||
                queue_level !== 4'd2) begin
                errors++;
                $display("FAIL stall%0d: valid=%b mask=%b level=%0d, required 1/1010/2",
                         i, spawn_if.spawn_valid, spawn_if.spawn_mask, queue_level);
            end
        end
        enable = 1'b0;
        cycle();
        checks++;
        if (spawn_if.spawn_valid !== 1'b0 || queue_level !== 4'd0) begin
            errors++;
            $display("FAIL disable: valid=%b level=%0d, required 0/0",
                     spawn_if.spawn_valid, queue_level);
        end
        enable = 1'b1;
        push(4'b0100);
        frame();
        checks++;
        if (spawn_if.spawn_valid !== 1'b1 || spawn_if.spawn_mask !== 4'b0100) begin
            errors++;
            $display("FAIL disable_idle: valid=%b mask=%b, required 1/0100",
                     spawn_if.spawn_valid, spawn_if.spawn_mask);
        end
    endtask

    task automatic test_zero_mask();
        logic [3:0] exp_lvl;
        lane_mask_t exp_m;
`ifdef BEAT_SCHED_DROP_EMPTY_EN
        exp_lvl = 4'd1;
        exp_m   = 4'b1000;
`else
        exp_lvl = 4'd2;
        exp_m   = 4'b0000;
`endif
        do_reset();
        push(4'b0000);
        push(4'b1000);
        checks++;
        if (queue_level !== exp_lvl) begin
            errors++;
            $display("FAIL zero_level: got %0d, required %0d", queue_level, exp_lvl);
        end
        frame();
        checks++;
        if (spawn_if.spawn_valid !== 1'b1 || spawn_if.spawn_mask !== exp_m) begin
            errors++;
            $display("FAIL zero_first: valid=%b mask=%b, required 1/%b",
                     spawn_if.spawn_valid, spawn_if.spawn_mask, exp_m);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 1; i <= 8; i++) push(4'(i));
        frame();
        spawn_if.spawn_ready = 1'b1;
        new_beat   = 1'b1;
        lane_mask  = 4'b1111;
        frame_tick = 1'b1;
        cycle();
        spawn_if.spawn_ready = 1'b0;
        new_beat   = 1'b0;
        lane_mask  = '0;
        frame_tick = 1'b0;
        checks++;
        if (queue_level !== 4'd8 || overflow !== 1'b0 || spawn_if.spawn_valid !== 1'b0) begin
            errors++;
            $display("FAIL full_push_pop: level=%0d ovf=%b valid=%b, required 8/0/0",
                     queue_level, overflow, spawn_if.spawn_valid);
        end
        do_reset();
        new_beat   = 1'b1;
        lane_mask  = 4'b0111;
        frame_tick = 1'b1;
        cycle();
        new_beat   = 1'b0;
        lane_mask  = '0;
        frame_tick = 1'b0;
        checks++;
        if (spawn_if.spawn_valid !== 1'b0 || queue_level !== 4'd1) begin
            errors++;
            $display("FAIL push_with_tick: valid=%b level=%0d, required 0/1",
                     spawn_if.spawn_valid, queue_level);
        end
        frame();
        checks++;
        if (spawn_if.spawn_valid !== 1'b1 || spawn_if.spawn_mask !== 4'b0111) begin
            errors++;
            $display("FAIL push_with_tick_next: valid=%b mask=%b, required 1/0111",
                     spawn_if.spawn_valid, spawn_if.spawn_mask);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic();
        test_holdoff();
        test_overflow();
        test_stall_disable();
        test_zero_mask();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/beat_scheduler.md
# beat_scheduler

Paces incoming beats from the SPI beat receiver into the note pattern generator. Each `new_beat`/`lane_mask` pair is queued in a small FIFO. On each frame tick, at most one queued beat is issued as a spawn command over a valid/ready handshake. A minimum number of frame ticks is always left between spawns. The block sits between the beat receiver and `pattern_gen` in the `clk` domain.

## Interface
Parameters:
- `DEPTH`, 8: FIFO entries; power of two, ≥2.
- `HOLDOFF_TICKS`, 2: frame ticks required after a spawn before the next spawn may be issued; 0 to 15.

Ports:
- `clk`, in, 1: system clock (48 MHz).
- `reset`, in, 1: synchronous, active-high.
- `enable`, in, 1: game running; low flushes and idles the block.
- `new_beat`, in, 1: one-cycle pulse from the receiver.
- `lane_mask`, in, 4: beat lanes; valid when `new_beat`=1.
- `frame_tick`, in, 1: one-cycle pulse per display frame.
- `spawn_valid`, out, 1: spawn command present.
- `spawn_mask`, out, 4: lanes to spawn; valid when `spawn_valid`=1.
- `spawn_ready`, in, 1: `pattern_gen` accepts the command.
- `clear_overflow`, in, 1: clears `overflow`.
- `queue_level`, out, $clog2(DEPTH)+1: number of entries currently queued.
- `overflow`, out, 1: sticky; set when a beat was dropped because the FIFO was full.

## Operation
- Push: `new_beat && enable` writes `lane_mask` at the FIFO tail.
  - Full with no pop that cycle: the beat is dropped and `overflow` is set.
  - Full with a pop that same cycle: the push is accepted.
- `overflow` clears on `clear_overflow`. If a drop and `clear_overflow` occur in the same cycle, set wins.
- FSM states (shared enum):
  - IDLE: when `frame_tick` && `queue_level`≠0, go to ISSUE.
  - ISSUE: `spawn_valid`=1 and `spawn_mask`=FIFO head. Once asserted, `spawn_mask` holds stable until the handshake completes.
    - On `spawn_ready`: pop the head. Go to HOLD with `hold_cnt`=`HOLDOFF_TICKS`, or straight to IDLE when `HOLDOFF_TICKS`=0.
    - `frame_tick` is ignored while in ISSUE.
  - HOLD: each `frame_tick` decrements `hold_cnt`. When `hold_cnt` reaches 0, go to IDLE. The tick that performs the final decrement does not itself trigger an issue.
- `enable`=0: synchronously empties the FIFO and forces IDLE. This aborts any pending spawn, so `spawn_valid` drops without `spawn_ready`; this is the only exception to the handshake hold rule. `overflow` is kept.
- Arithmetic:
  - Read/write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
  - `queue_level` is a separate counter saturating at 0..DEPTH.
  - `hold_cnt` is 4 bits.
- Reset: FIFO empty, state IDLE, `spawn_valid`=0, `spawn_mask`=0, `queue_level`=0, `overflow`=0, `hold_cnt`=0.

## Timing
- Push: `queue_level` updates the cycle after `new_beat`.
- Issue eligibility is evaluated on registered state only. A beat pushed in the same cycle as `frame_tick` waits for the next tick.
- `frame_tick` in IDLE with a non-empty queue: `spawn_valid`=1 on the next cycle.
- Handshake: `spawn_valid && spawn_ready` on cycle N means the pop is visible and `spawn_valid`=0 on cycle N+1. The earliest next issue is `HOLDOFF_TICKS`+1 frame ticks later.
- Empty queue: no spawn. A `frame_tick` seen while empty is not remembered.
- All outputs are registered. `enable` takes effect the cycle after it is sampled.

## Configuration
- `BEAT_SCHED_DROP_EMPTY_EN` defined: beats with `lane_mask`=4'b0000 are discarded at push. They do not occupy the FIFO and never set `overflow`.
- Undefined: zero masks are queued and issued like any other beat. They consume a spawn slot and a holdoff, giving `pattern_gen` a rest beat.

## Structure
- Package `beat_pkg`:
  - `LANES`=4.
  - `lane_mask_t` (logic [LANES-1:0]).
  - `sched_state_t` enum {IDLE, ISSUE, HOLD}.
- Sub-module `beat_fifo`: parameterised DEPTH × `lane_mask_t` storage.
  - Push/pop, synchronous flush, `level` count, full/empty flags.
  - Same-cycle push+pop supported when full or empty. Push+pop on empty: the pop is ignored and the push is accepted.
- `beat_scheduler` holds the FSM, holdoff counter, overflow flag and push gating.

## Test plan
- Reset, then push 4'b0101; tick → `spawn_valid`=1 with `spawn_mask`=4'b0101 one cycle after the tick; `spawn_ready`=1 → `queue_level`=0 and `spawn_valid`=0.
- Push 3 beats with `HOLDOFF_TICKS`=2 and `spawn_ready` tied high → spawns occur on ticks 1, 4 and 7 only.
- Push 9 beats with `DEPTH`=8 and no ticks → `queue_level`=8, `overflow`=1, and the 9th mask is absent from later spawns. Then assert `clear_overflow` → `overflow`=0.
- Hold `spawn_ready`=0 for 5 cycles in ISSUE while ticks occur → `spawn_mask` stays stable and no extra pop happens. Then deassert `enable` → `spawn_valid`=0, `queue_level`=0, state IDLE.
- Push 4'b0000 then 4'b1000 → with the macro defined, `queue_level`=1 and the first spawn is 4'b1000; without it, `queue_level`=2 and the first spawn is 4'b0000.
- Push on the same cycle as a pop while full, and as `frame_tick` → the push is accepted and `overflow` stays 0. The pushed beat is not issued by that same tick.
